// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flops for the pipelined core; register 0 is never busy.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int AW    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [AW-1:0]         set_addr,
    input  logic                  clr_en,
    input  logic [AW-1:0]         clr_addr,
    input  logic [NREAD*AW-1:0]   lk_addr,
    output logic [NREAD-1:0]      lk_busy
);

    logic [NREGS-1:0] busy;

    // A new producer issued in the same cycle as the old one retires keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (set_en && set_addr == AW'(i))
                    busy[i] <= 1'b1;
                else if (clr_en && clr_addr == AW'(i))
                    busy[i] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_lk
        assign lk_busy[k] = busy[lk_addr[k*AW +: AW]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zero register, write bypass, busy scoreboard
// and a sequential clear engine so storage needs no bulk reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  busy_set,
    input  logic [AW-1:0]         busy_addr
);

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] mem [NREGS];

    logic            run;
    logic            acc;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [NREAD-1:0] sb_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == CLEAR) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(NREGS - 1)) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end

    assign run = (state == RUN);
    assign acc = run && wr_en && (wr_addr != '0);

    // Clear engine and architectural writes share the single storage write port.
    always_comb begin
        we = 1'b0;
        wa = cnt;
        wd = '0;
        if (!run) begin
            we = !reset;
        end else if (acc) begin
            we = 1'b1;
            wa = wr_addr;
            wd = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    regfile_scoreboard #(.NREGS(NREGS), .NREAD(NREAD), .AW(AW)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (run && busy_set),
        .set_addr (busy_addr),
        .clr_en   (acc),
        .clr_addr (wr_addr),
        .lk_addr  (rd_addr),
        .lk_busy  (sb_busy)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = rd_addr[k*AW +: AW];
        assign hit = (BYPASS != 0) && acc && (wr_addr == a);
        assign rd_data[k*XLEN +: XLEN] = (!run || a == '0) ? '0 :
                                         hit ? wr_data : mem[a];
        assign rd_busy[k] = run && !hit && sb_busy[k];
    end

endmodule
